// File: rtl/fp_sub_seq.sv
// fp_sub_seq: multi-cycle IEEE 754 single-precision subtractor (diff = a - b).
// Truncating rounding. Denormals are flushed to zero. No guard/round/sticky bits.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   start - operation request, sampled only while idle
//   a, b  - minuend / subtrahend (binary32)
//   diff  - result, held until the next completion
//   busy  - high whenever the block is not idle
//   done  - one-cycle pulse marking diff valid
module fp_sub_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] diff,
    output logic        busy,
    output logic        done
);

    localparam int unsigned EXP_W     = 8;
    localparam int unsigned MAN_W     = 23;
    localparam int unsigned SIG_W     = MAN_W + 1;
    localparam int unsigned ACC_W     = SIG_W + 1;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned MAX_SHIFT = 26;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic               sign_q, sign_d;
    logic               sub_q, sub_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic [ACC_W-1:0]   mant_q, mant_d;
    logic [SIG_W-1:0]   mant_s_q, mant_s_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        diff_q, diff_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Operand decode; b is used with its sign inverted so a - b becomes a + (-b).
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_man, b_man;
    logic             a_sign, bn_sign;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic             b_bigger;

    assign a_sign  = a[31];
    assign bn_sign = ~b[31];
    assign a_exp   = a[30:23];
    assign b_exp   = b[30:23];
    assign a_man   = a[22:0];
    assign b_man   = b[22:0];
    assign a_zero  = (a_exp == '0);
    assign b_zero  = (b_exp == '0);
    assign a_inf   = (a_exp == '1) && (a_man == '0);
    assign b_inf   = (b_exp == '1) && (b_man == '0);
    assign a_nan   = (a_exp == '1) && (a_man != '0);
    assign b_nan   = (b_exp == '1) && (b_man != '0);
    assign b_bigger = {b_exp, b_man} > {a_exp, a_man};

    // Special-operand short cut straight to DONE.
    logic        spec_hit;
    logic [31:0] spec_res;

    always_comb begin
        spec_hit = 1'b1;
        spec_res = 32'h0000_0000;
        if (a_nan || b_nan) begin
            spec_res = QNAN;
        end else if (a_inf && b_inf) begin
            // inf + (-inf) after sign inversion of b is invalid
            spec_res = (a_sign != bn_sign) ? QNAN : a;
        end else if (a_inf) begin
            spec_res = a;
        end else if (b_inf) begin
            spec_res = {bn_sign, b[30:0]};
        end else if (a_zero && b_zero) begin
            spec_res = 32'h0000_0000;
        end else if (a_zero) begin
            spec_res = {bn_sign, b[30:0]};
        end else if (b_zero) begin
            spec_res = a;
        end else begin
            spec_hit = 1'b0;
        end
    end

    // Larger-magnitude operand first; alignment distance saturates once the
    // smaller significand would be fully shifted out.
    logic             l_sign, s_sign;
    logic [EXP_W-1:0] l_exp, s_exp, exp_gap;
    logic [MAN_W-1:0] l_man, s_man;
    logic [CNT_W-1:0] align_cnt;

    assign l_sign    = b_bigger ? bn_sign : a_sign;
    assign s_sign    = b_bigger ? a_sign  : bn_sign;
    assign l_exp     = b_bigger ? b_exp   : a_exp;
    assign s_exp     = b_bigger ? a_exp   : b_exp;
    assign l_man     = b_bigger ? b_man   : a_man;
    assign s_man     = b_bigger ? a_man   : b_man;
    assign exp_gap   = l_exp - s_exp;
    assign align_cnt = (exp_gap > EXP_W'(MAX_SHIFT)) ? CNT_W'(MAX_SHIFT) : exp_gap[CNT_W-1:0];

    // State register and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            sub_q    <= 1'b0;
            exp_q    <= '0;
            mant_q   <= '0;
            mant_s_q <= '0;
            cnt_q    <= '0;
            diff_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            sub_q    <= sub_d;
            exp_q    <= exp_d;
            mant_q   <= mant_d;
            mant_s_q <= mant_s_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        sub_d    = sub_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        mant_s_d = mant_s_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (spec_hit) begin
                        diff_d  = spec_res;
                        state_d = DONE;
                    end else begin
                        sign_d   = l_sign;
                        sub_d    = (l_sign != s_sign);
                        exp_d    = l_exp;
                        mant_d   = {2'b01, l_man};
                        mant_s_d = {1'b1, s_man};
                        cnt_d    = align_cnt;
                        state_d  = ALIGN;
                    end
                end
            end
            ALIGN: begin
                if (cnt_q != '0) begin
                    mant_s_d = mant_s_q >> 1;
                    cnt_d    = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ADD;
                end
            end
            ADD: begin
                // Larger magnitude is in mant_q, so the subtraction cannot wrap.
                if (sub_q) begin
                    mant_d = mant_q - {1'b0, mant_s_q};
                end else begin
                    mant_d = mant_q + {1'b0, mant_s_q};
                end
                state_d = NORM;
            end
            NORM: begin
                // One shift per cycle; range limits are checked on the following cycle.
                if (mant_q == '0) begin
                    diff_d  = 32'h0000_0000;
                    state_d = DONE;
                end else if (exp_q == '1) begin
                    diff_d  = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    state_d = DONE;
                end else if (exp_q == '0) begin
                    diff_d  = 32'h0000_0000;
                    state_d = DONE;
                end else if (mant_q[ACC_W-1]) begin
                    mant_d = mant_q >> 1;
                    exp_d  = exp_q + EXP_W'(1);
                end else if (!mant_q[SIG_W-1]) begin
                    mant_d = mant_q << 1;
                    exp_d  = exp_q - EXP_W'(1);
                end else begin
                    diff_d  = {sign_q, exp_q, mant_q[MAN_W-1:0]};
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state.
    always_comb begin
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign diff = diff_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_fp_sub_seq.sv
// Directed testbench for fp_sub_seq with a cycle-level behavioural reference.
module tb_fp_sub_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] diff;
    logic        busy;
    logic        done;

    int n_vec;
    int n_err;
    bit chk_en;

    fp_sub_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .diff  (diff),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: real-valued subtraction with truncating alignment and
    // normalisation, plus the cycle count implied by the state sequence
    // (lat = edges from the start edge until DONE is entered).
    function automatic logic [31:0] model_sub(input logic [31:0] x, input logic [31:0] y,
                                              output int lat);
        bit      sx, sy, sl, ss, zx, zy, ix, iy, nx, ny, sw;
        int      ex, ey, el, es, d, e, s;
        longint  mx, my, ml, ms, sum;
        logic [31:0] yn;
        sx = x[31];
        sy = ~y[31];
        yn = {sy, y[30:0]};
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        mx = longint'(x[22:0]);
        my = longint'(y[22:0]);
        zx = (ex == 0);
        zy = (ey == 0);
        ix = (ex == 255) && (mx == 0);
        iy = (ey == 255) && (my == 0);
        nx = (ex == 255) && (mx != 0);
        ny = (ey == 255) && (my != 0);
        lat = 0;
        if (nx || ny) return 32'h7FC0_0000;
        if (ix && iy) return (sx != sy) ? 32'h7FC0_0000 : x;
        if (ix) return x;
        if (iy) return yn;
        if (zx && zy) return 32'h0;
        if (zx) return yn;
        if (zy) return x;
        sw = (y[30:0] > x[30:0]);
        sl = sw ? sy : sx;
        ss = sw ? sx : sy;
        el = sw ? ey : ex;
        es = sw ? ex : ey;
        ml = (sw ? my : mx) + (64'd1 << 23);
        ms = (sw ? mx : my) + (64'd1 << 23);
        d  = el - es;
        if (d > 26) d = 26;
        ms  = ms >> d;
        sum = (sl == ss) ? ml + ms : ml - ms;
        lat = (d + 1) + 1;
        if (sum == 0) begin
            lat += 1;
            return 32'h0;
        end
        e = el;
        s = 0;
        while (sum >= (64'd1 << 24)) begin
            sum = sum >> 1;
            e++;
            s++;
        end
        if (e >= 255) begin
            lat += s + 1;
            return {sl, 8'hFF, 23'h0};
        end
        while (sum < (64'd1 << 23)) begin
            sum = sum << 1;
            e--;
            s++;
            if (e == 0) begin
                lat += s + 1;
                return 32'h0;
            end
        end
        lat += s + 1;
        return {sl, 8'(e), 23'(sum)};
    endfunction

    // Expected port behaviour, advanced on the same edges as the DUT.
    int          m_phase;   // 0 idle, 1 working, 2 done cycle
    int          m_rem;
    logic [31:0] m_pend;
    logic [31:0] m_diff;

    always @(posedge clk or negedge rst_n) begin
        int          l;
        logic [31:0] r;
        if (!rst_n) begin
            m_phase <= 0;
            m_rem   <= 0;
            m_pend  <= 32'h0;
            m_diff  <= 32'h0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    r = model_sub(a, b, l);
                    if (l == 0) begin
                        m_phase <= 2;
                        m_diff  <= r;
                    end else begin
                        m_phase <= 1;
                        m_rem   <= l;
                        m_pend  <= r;
                    end
                end
                1: begin
                    if (m_rem == 1) begin
                        m_phase <= 2;
                        m_diff  <= m_pend;
                    end
                    m_rem <= m_rem - 1;
                end
                default: m_phase <= 0;
            endcase
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the reference, away from the active edge.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check32("busy", 32'(busy), 32'(m_phase != 0));
            check32("done", 32'(done), 32'(m_phase == 2));
            check32("diff", diff, m_diff);
        end
    end

    typedef struct {
        string       name;
        logic [31:0] av;
        logic [31:0] bv;
        logic [31:0] res;
        int          lat;
        bit          glitch;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input string n, input logic [31:0] av, input logic [31:0] bv,
                           input logic [31:0] res, input int lat, input bit g);
        vec_t v;
        v.name = n; v.av = av; v.bv = bv; v.res = res; v.lat = lat; v.glitch = g;
        vecs.push_back(v);
    endtask

    // One operation: start for one cycle, then scramble the operand inputs,
    // optionally pulse start again while busy, and wait for done.
    task automatic run_vec(input vec_t v);
        int          cyc;
        int          mlat;
        logic [31:0] mres;
        mres = model_sub(v.av, v.bv, mlat);
        check32({v.name, " model result"}, mres, v.res);
        check32({v.name, " model latency"}, 32'(mlat), 32'(v.lat));
        @(negedge clk);
        a = v.av;
        b = v.bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        cyc = 1;
        while (!done && cyc < 200) begin
            if (v.glitch && cyc == 2) begin
                start = 1'b1;
                a = 32'h4120_0000;
                b = 32'h3F80_0000;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL %s timeout: no done within %0d cycles", v.name, cyc);
        end else begin
            check32({v.name, " latency"}, 32'(cyc - 1), 32'(v.lat));
            check32({v.name, " diff"}, diff, v.res);
        end
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = 32'h0;
        b      = 32'h0;

        add_vec("3-2",        32'h4040_0000, 32'h4000_0000, 32'h3F80_0000, 4,  1'b0);
        add_vec("7.875-0.1875", 32'h40FC_0000, 32'h3E40_0000, 32'h40F6_0000, 8, 1'b0);
        add_vec("-3-2",       32'hC040_0000, 32'h4000_0000, 32'hC0A0_0000, 4,  1'b0);
        add_vec("1-1",        32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 3,  1'b0);
        add_vec("inf-inf",    32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 0,  1'b0);
        add_vec("1-0",        32'h3F80_0000, 32'h0000_0000, 32'h3F80_0000, 0,  1'b0);
        add_vec("nan-1",      32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 0,  1'b0);
        add_vec("1-inf",      32'h3F80_0000, 32'h7F80_0000, 32'hFF80_0000, 0,  1'b0);
        add_vec("0-2",        32'h0000_0000, 32'h4000_0000, 32'hC000_0000, 0,  1'b0);
        add_vec("den-den",    32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 0,  1'b0);
        add_vec("overflow",   32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, 4,  1'b0);
        add_vec("underflow",  32'h0080_0001, 32'h0080_0000, 32'h0000_0000, 4,  1'b0);
        add_vec("2^23-1",     32'h4B00_0000, 32'h3F80_0000, 32'h4AFF_FFFE, 27, 1'b0);
        add_vec("gap-sat",    32'h4F80_0000, 32'h3F80_0000, 32'h4F80_0000, 29, 1'b0);
        add_vec("busy-start", 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000, 4,  1'b1);

        repeat (2) @(negedge clk);
        check32("reset busy", 32'(busy), 32'h0);
        check32("reset done", 32'(done), 32'h0);
        check32("reset diff", diff, 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        chk_en = 1'b1;

        // Consecutive calls start in the idle cycle right after DONE.
        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset while aligning: outputs clear at once and the operation is dropped.
        @(negedge clk);
        a = 32'h40FC_0000;
        b = 32'h3E40_0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check32("mid-reset busy", 32'(busy), 32'h0);
        check32("mid-reset done", 32'(done), 32'h0);
        check32("mid-reset diff", diff, 32'h0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        run_vec(vecs[0]);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
